// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: decode handoff record, FSM encoding and
// the bubble instruction.
package Bundle;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } FetchState;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } FetchToDecode;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} pairs between instruction memory and decode.
// Flush has priority over push and pop.
module fetch_buffer #(
    parameter  int unsigned DEPTH = 1,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [31:0]      push_pc_i,
    input  logic [31:0]      push_inst_i,
    output logic [31:0]      head_pc_o,
    output logic [31:0]      head_inst_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][31:0] pc_q;
    logic [DEPTH-1:0][31:0] inst_q;
    logic [PTR_W-1:0]       rd_q, wr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign count_o     = cnt_q;
    assign head_pc_o   = pc_q[rd_q];
    assign head_inst_o = inst_q[rd_q];
    assign do_pop      = pop_i && !empty_o;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push     = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= '0;
            inst_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                pc_q[wr_q]   <= push_pc_i;
                inst_q[wr_q] <= push_inst_i;
                wr_q         <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, in-order responses, buffer to decode.
// FETCH_SKID_BUFFER_EN selects a 2-entry buffer (1 instr/cycle) instead of 1 entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = Bundle::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_stall,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);
    import Bundle::*;

`ifdef FETCH_SKID_BUFFER_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    FetchState        state_q;
    logic [31:0]      fetch_pc_q, req_pc_q, last_pc_q;
    logic             run_q;
    logic             buf_full, buf_empty;
    logic [CNT_W-1:0] buf_count;
    logic [31:0]      head_pc, head_inst;
    logic             resp_ok, pop, accept, slot_ok;
    logic [CNT_W:0]   occ_after;
    logic             redirect_lsb_unused;
    FetchToDecode     dec_out;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Redirect kills the in-flight response and any pop this cycle.
    assign resp_ok = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
    assign pop     = !buf_empty && !dec_stall && !redirect_valid;

    // A new request reserves one slot for its eventual response.
    assign occ_after = {1'b0, buf_count} + (CNT_W+1)'(resp_ok) - (CNT_W+1)'(pop);
    assign slot_ok   = occ_after < (CNT_W+1)'(DEPTH);

    assign imem_req_valid = run_q && !redirect_valid && slot_ok && !(buf_full && !pop)
                          && ((state_q == IDLE) || resp_ok);
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (resp_ok),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_pc_i   (req_pc_q),
        .push_inst_i (imem_resp_data),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    always_comb begin
        dec_out = '{valid: !buf_empty, inst: NOP_INST, pc: last_pc_q};
        if (!buf_empty) begin
            dec_out.inst = head_inst;
            dec_out.pc   = head_pc;
        end
    end

    assign dec_valid = dec_out.valid;
    assign dec_inst  = dec_out.inst;
    assign dec_pc    = dec_out.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            req_pc_q   <= {RESET_PC[31:2], 2'b00};
            last_pc_q  <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (pop) last_pc_q <= head_pc;
            if (accept) begin
                req_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                // Still owed a response that must be dropped -> DRAIN.
                if ((state_q == WAIT || state_q == DRAIN) && !imem_resp_valid) state_q <= DRAIN;
                else                                                           state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (accept) state_q <= WAIT;
                    WAIT:    if (imem_resp_valid) state_q <= accept ? WAIT : IDLE;
                    DRAIN:   if (imem_resp_valid) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: queue-level model of buffer and memory,
// checked every cycle, plus directed literal checks of addresses and reset.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_SKID_BUFFER_EN
    localparam int DEPTH    = 2;
    localparam int MIN_POPS = 10;
`else
    localparam int DEPTH    = 1;
    localparam int MIN_POPS = 5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic [31:0] imem_req_addr, imem_resp_data = '0;
    logic        redirect_valid = 1'b0, dec_stall = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic [31:0] dec_inst, dec_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .dec_stall(dec_stall), .dec_valid(dec_valid),
        .dec_inst(dec_inst), .dec_pc(dec_pc)
    );

    int checks = 0;
    int errors = 0;

    // Model: decode-visible buffer contents, next fetch address, memory owed response.
    logic [31:0] q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_pc = RESET_PC, last_pc = RESET_PC, mem_addr = '0;
    bit          started = 1'b0, busy = 1'b0, stale = 1'b0, last_rv = 1'b0;
    int          lat = 0;
    int          p_ready = 100, max_lat = 0, p_stall = 0, p_redir = 0;
    int          force_rd = 0;
    logic [31:0] force_pc = '0;
    int          acc_mark = 0, pop_mark = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit rsp, rdr, fired, good, pop, rv_exp, rv_s;
        logic [31:0] rp_s, addr_s;
        @(negedge clk);
        rsp             = busy && (lat == 0);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? hash(mem_addr) : $urandom;
        imem_req_ready  = ($urandom_range(99) < p_ready);
        dec_stall       = ($urandom_range(99) < p_stall);
        rdr             = ($urandom_range(999) < p_redir);
        redirect_pc     = $urandom;
        if ($urandom_range(7) == 0) redirect_pc[31:4] = '1;
        fired = 1'b0;
        if ((force_rd == 1 && busy && !rsp && !stale) ||
            (force_rd == 2 && rsp && !stale) || (force_rd == 3)) begin
            rdr = 1'b1; redirect_pc = force_pc; force_rd = 0; fired = 1'b1;
        end
        redirect_valid = rdr;
        #1;
        good   = rsp && !stale && !rdr;
        pop    = (q.size() > 0) && !dec_stall && !rdr;
        rv_exp = started && !rdr && (!busy || good) &&
                 (int'(q.size()) + int'(good) - int'(pop) < DEPTH);
        chk("dec_valid", {31'b0, dec_valid}, {31'b0, q.size() > 0});
        chk("dec_pc", dec_pc, (q.size() > 0) ? q[0] : last_pc);
        chk("dec_inst", dec_inst, (q.size() > 0) ? hash(q[0]) : NOP);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, rv_exp});
        if (rv_exp && imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
        rv_s = imem_req_valid; addr_s = imem_req_addr; rp_s = redirect_pc;
        last_rv = rv_s;
        @(posedge clk);
        if (pop) begin last_pc = q.pop_front(); pop_log.push_back(last_pc); end
        if (rdr) begin
            q.delete();
            m_pc = {rp_s[31:2], 2'b00};
            if (busy && !rsp) stale = 1'b1;
        end else if (good) q.push_back(mem_addr);
        if (rsp) begin busy = 1'b0; stale = 1'b0; end
        else if (busy) lat--;
        if (rv_s && imem_req_ready) begin
            busy = 1'b1; mem_addr = addr_s; lat = $urandom_range(max_lat);
            acc_log.push_back(addr_s);
        end
        if (rv_exp && imem_req_ready) m_pc += 32'd4;
        if (fired) begin acc_mark = acc_log.size(); pop_mark = pop_log.size(); end
        started = 1'b1;
    endtask

    // Expects reset already asserted; releases it shortly after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        imem_resp_valid = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; dec_stall = 1'b0;
        q.delete(); m_pc = RESET_PC; last_pc = RESET_PC;
        started = 1'b0; busy = 1'b0; stale = 1'b0; force_rd = 0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic force_redirect(input int kind, input logic [31:0] pc, input string name);
        force_rd = kind; force_pc = pc;
        for (int i = 0; i < 60 && force_rd != 0; i++) cycle();
        chk(name, force_rd, 0);
        force_rd = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_dec_pc", dec_pc, RESET_PC);
        chk("rst_dec_inst", dec_inst, NOP);

        // Sequential fetch, single-cycle memory
        acc_mark = acc_log.size();
        repeat (10) cycle();
        chk("seq_addr0", qat(acc_log, acc_mark), 32'h0000_2000);
        chk("seq_addr1", qat(acc_log, acc_mark + 1), 32'h0000_2004);
        chk("seq_addr2", qat(acc_log, acc_mark + 2), 32'h0000_2008);
        chk("seq_pop0", qat(pop_log, 0), 32'h0000_2000);
        begin
            int n0;
            n0 = pop_log.size();
            repeat (10) cycle();
            chk("throughput", {31'b0, (pop_log.size() - n0) >= MIN_POPS}, 32'd1);
        end

        // Decode stall holds buffer and blocks requests once full
        p_stall = 100;
        repeat (6) cycle();
        chk("stall_no_req", {31'b0, last_rv}, 32'd0);
        p_stall = 0;
        repeat (6) cycle();

        // Redirect while a request is outstanding
        max_lat = 3;
        force_redirect(1, 32'h0000_3000, "redir_wait_fired");
        repeat (12) cycle();
        chk("redir_wait_addr", qat(acc_log, acc_mark), 32'h0000_3000);
        chk("redir_wait_pop", qat(pop_log, pop_mark), 32'h0000_3000);

        // Redirect coincident with a response
        max_lat = 0;
        force_redirect(2, 32'h4000_0100, "redir_resp_fired");
        repeat (10) cycle();
        chk("redir_resp_pop", qat(pop_log, pop_mark), 32'h4000_0100);

        // Wrap at the top of the address space (low bits ignored)
        force_redirect(3, 32'hFFFF_FFFF, "wrap_fired");
        repeat (12) cycle();
        chk("wrap_addr0", qat(acc_log, acc_mark), 32'hFFFF_FFFC);
        chk("wrap_addr1", qat(acc_log, acc_mark + 1), 32'h0000_0000);

        // Random traffic
        p_ready = 70; max_lat = 3; p_stall = 30; p_redir = 50;
        repeat (3000) cycle();

        // Asynchronous reset while waiting on memory
        p_ready = 100; p_stall = 0; p_redir = 0;
        for (int i = 0; i < 100 && !(busy && !stale && lat > 0); i++) cycle();
        chk("reach_wait", {31'b0, busy && !stale}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("arst_dec_inst", dec_inst, NOP);
        chk("arst_dec_pc", dec_pc, RESET_PC);
        do_reset();
        acc_mark = acc_log.size();
        repeat (8) cycle();
        chk("refetch_addr", qat(acc_log, acc_mark), 32'h0000_2000);

        p_ready = 80; p_stall = 20; p_redir = 30;
        repeat (300) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
